// File: rtl/polymult_dummy_sched_if.sv
// Host/core signal bundle for the dummy-operation scheduler.
// slave = scheduler side, master = register block plus core side.
interface polymult_dummy_sched_if #(
    parameter int unsigned DW = 128
);
    logic          start_i;
    logic [DW-1:0] key_i;
    logic [DW-1:0] data_i;
    logic          dummy_en_i;
    logic [2:0]    num_dummy_i;
    logic          seed_load_i;
    logic [31:0]   seed_i;
    logic          busy_o;
    logic          done_o;
    logic [DW-1:0] data_o;
    logic          err_o;
    logic          trig_o;
    logic          core_load_o;
    logic [DW-1:0] core_key_o;
    logic [DW-1:0] core_data_o;
    logic [DW-1:0] core_data_i;
    logic          core_busy_i;

    modport slave (
        input  start_i, key_i, data_i, dummy_en_i, num_dummy_i,
        input  seed_load_i, seed_i, core_data_i, core_busy_i,
        output busy_o, done_o, data_o, err_o, trig_o,
        output core_load_o, core_key_o, core_data_o
    );

    modport master (
        output start_i, key_i, data_i, dummy_en_i, num_dummy_i,
        output seed_load_i, seed_i, core_data_i, core_busy_i,
        input  busy_o, done_o, data_o, err_o, trig_o,
        input  core_load_o, core_key_o, core_data_o
    );
endinterface

// File: rtl/polymult_dummy_sched.sv
// Runs one real poly_mult operation hidden among LFSR-fed dummies,
// with the real slot picked pseudo-randomly per request.
module polymult_dummy_sched #(
    parameter int unsigned pDATA_WIDTH   = 128,
    parameter logic [31:0] pSEED_DEFAULT = 32'h1D2C_3B4A,
    parameter int unsigned pTIMEOUT      = 15
) (
    input logic                   clk,
    input logic                   resetn,
    polymult_dummy_sched_if.slave bus
);
    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam int unsigned REP  = pDATA_WIDTH / 32;
    localparam int unsigned TW   = $clog2(pTIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, PICK, ISSUE, WAIT_HI, WAIT_LO, NEXT, FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            lfsr_q, lfsr_d, lfsr_nx;
    logic [pDATA_WIDTH-1:0] key_q, key_d, text_q, text_d;
    logic [pDATA_WIDTH-1:0] res_q, res_d, dout_q, dout_d;
    logic [pDATA_WIDTH-1:0] op_q, op_d, operand;
    logic [2:0]             last_q, last_d, slot_q, slot_d;
    logic [2:0]             ridx_q, ridx_d, idx_q, idx_d;
    logic                   first_q, first_d, err_q, err_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [3:0]             w;
    logic                   real_slot;

    assign lfsr_nx   = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 32'h0);
    assign real_slot = (slot_q == ridx_q);
    assign operand   = real_slot ? text_q : {REP{lfsr_q}};
    // First PICK cycle draws from the LFSR, later ones reduce the remainder
    assign w = first_q ? {1'b0, lfsr_q[2:0]} : {1'b0, idx_q};

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        key_d   = key_q;
        text_d  = text_q;
        res_d   = res_q;
        dout_d  = dout_q;
        op_d    = op_q;
        last_d  = last_q;
        slot_d  = slot_q;
        ridx_d  = ridx_q;
        idx_d   = idx_q;
        first_d = first_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (bus.seed_load_i)
                    lfsr_d = (bus.seed_i == 32'h0) ? pSEED_DEFAULT : bus.seed_i;
                if (bus.start_i) begin
                    key_d   = bus.key_i;
                    text_d  = bus.data_i;
                    last_d  = bus.dummy_en_i ? bus.num_dummy_i : 3'd0;
                    err_d   = 1'b0;
                    slot_d  = 3'd0;
                    first_d = 1'b1;
                    state_d = PICK;
                end
            end
            PICK: begin
                if (first_q) begin
                    lfsr_d  = lfsr_nx;
                    first_d = 1'b0;
                end
                if (w > {1'b0, last_q}) begin
                    idx_d = 3'(w - ({1'b0, last_q} + 4'd1));
                end else begin
                    ridx_d  = w[2:0];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                op_d    = operand;
                lfsr_d  = lfsr_nx;
                tmo_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.core_busy_i) begin
                    state_d = WAIT_LO;
                end else if (tmo_q == TW'(pTIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = NEXT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WAIT_LO: begin
                if (!bus.core_busy_i) begin
                    if (real_slot) res_d = bus.core_data_i;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (slot_q == last_q) begin
                    state_d = FIN;
                end else begin
                    slot_d  = slot_q + 3'd1;
                    state_d = ISSUE;
                end
            end
            FIN: begin
                dout_d  = res_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            lfsr_q  <= pSEED_DEFAULT;
            key_q   <= '0;
            text_q  <= '0;
            res_q   <= '0;
            dout_q  <= '0;
            op_q    <= '0;
            last_q  <= '0;
            slot_q  <= '0;
            ridx_q  <= '0;
            idx_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            key_q   <= key_d;
            text_q  <= text_d;
            res_q   <= res_d;
            dout_q  <= dout_d;
            op_q    <= op_d;
            last_q  <= last_d;
            slot_q  <= slot_d;
            ridx_q  <= ridx_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.busy_o      = (state_q != IDLE) && (state_q != FIN);
    assign bus.done_o      = (state_q == FIN);
    assign bus.data_o      = (state_q == FIN) ? res_q : dout_q;
    assign bus.err_o       = err_q;
    assign bus.trig_o      = real_slot && ((state_q == ISSUE) ||
                             (state_q == WAIT_HI) || (state_q == WAIT_LO));
    assign bus.core_load_o = (state_q == ISSUE);
    assign bus.core_key_o  = key_q;
    // Operand is live in the load cycle and held until the next load
    assign bus.core_data_o = (state_q == ISSUE) ? operand : op_q;
endmodule
